// File: rtl/instr_encoder.sv
// RV32I instruction encoder: checks a decoded operation, packs it into a 32-bit word
// and queues the result in a small output FIFO with saturating encode/error counters.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_class,
  input  logic [2:0]       funct3,
  input  logic             alt,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE_OCC  = OCC_W'(1);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8
  } op_class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic signed [31:0] simm;
  logic               fits_i;
  logic               fits_b;
  logic               fits_j;
  logic               is_shift;
  logic [6:0]         funct7;
  logic               legal;
  logic [31:0]        word;
  logic [31:0]        enc_word;
  logic               enc_err;

  assign simm     = imm;
  assign fits_i   = (simm >= -2048) && (simm <= 2047);
  assign fits_b   = !imm[0] && (simm >= -4096) && (simm <= 4094);
  assign fits_j   = !imm[0] && (simm >= -1048576) && (simm <= 1048574);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign funct7   = alt ? 7'b0100000 : 7'b0000000;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    legal = 1'b0;
    word  = NOP;
    case (op_class)
      CLS_R: begin
        legal = !alt || (funct3 == 3'b000) || (funct3 == 3'b101);
        word  = {funct7, rs2, rs1, funct3, rd, OPC_R};
      end
      CLS_I: begin
        // Shift amounts are unsigned, so a negative imm fails the <= 31 test.
        legal = (!alt || (funct3 == 3'b101)) && (is_shift ? (imm <= 32'd31) : fits_i);
        word  = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, OPC_I}
                         : {imm[11:0], rs1, funct3, rd, OPC_I};
      end
      CLS_LOAD: begin
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111) && fits_i;
        word  = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      end
      CLS_STORE: begin
        legal = (funct3 <= 3'b010) && fits_i;
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011) && fits_b;
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      end
      CLS_LUI: begin
        legal = (imm[11:0] == 12'd0);
        word  = {imm[31:12], rd, OPC_LUI};
      end
      CLS_AUIPC: begin
        legal = (imm[11:0] == 12'd0);
        word  = {imm[31:12], rd, OPC_AUIPC};
      end
      CLS_JAL: begin
        legal = fits_j;
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      CLS_JALR: begin
        legal = (funct3 == 3'b000) && fits_i;
        word  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      default: begin
        legal = 1'b0;
        word  = NOP;
      end
    endcase
    enc_err  = !legal;
    enc_word = legal ? word : NOP;
  end

  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_ready  = (count < FULL_OCC);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rd_next   = rd_ptr + 1'b1;

  // NOTE: storage carries no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_word};
  end

  // Head is a register so it keeps its last value once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_instr <= '0;
      out_err   <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (enc_err) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
        end else begin
          if (enc_count != '1) enc_count <= enc_count + 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        if (count != ONE_OCC) begin
          out_instr <= mem[rd_next][31:0];
          out_err   <= mem[rd_next][32];
        end else if (push) begin
          out_instr <= enc_word;
          out_err   <= enc_err;
        end
      end else if (push && (count == '0)) begin
        out_instr <= enc_word;
        out_err   <= enc_err;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure, reset,
// then random traffic against an arithmetic reference encoder and queue model.
module tb_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_class;
  logic [2:0]       funct3;
  logic             alt;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .alt(alt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [32:0] model_q[$];
  logic [32:0] last_head = '0;
  int          exp_enc = 0;
  int          exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint p2(input int n);
    return longint'(1) << n;
  endfunction

  // Reference encoder built from field positions by arithmetic; returns {err, word}.
  function automatic logic [32:0] ref_enc(input int cls, input int f3, input int a,
                                          input int d, input int s1, input int s2,
                                          input logic [31:0] imm_v);
    longint s = longint'($signed(imm_v));
    longint u = longint'(imm_v);
    bit     fits12 = (s >= -2048) && (s <= 2047);
    bit     ok = 0;
    longint w = 0;
    longint base = d * p2(7) + f3 * p2(12) + s1 * p2(15);
    case (cls)
      0: begin
        ok = (a == 0) || (f3 == 0) || (f3 == 5);
        w  = 'h33 + base + s2 * p2(20) + (a ? 32 : 0) * p2(25);
      end
      1: begin
        if (f3 == 1 || f3 == 5) begin
          ok = ((a == 0) || (f3 == 5)) && (s >= 0) && (s <= 31);
          w  = 'h13 + base + (u % 32) * p2(20) + (a ? 32 : 0) * p2(25);
        end else begin
          ok = (a == 0) && fits12;
          w  = 'h13 + base + (u % 4096) * p2(20);
        end
      end
      2: begin
        ok = (f3 != 3) && (f3 != 6) && (f3 != 7) && fits12;
        w  = 'h03 + base + (u % 4096) * p2(20);
      end
      3: begin
        ok = (f3 <= 2) && fits12;
        w  = 'h23 + (u % 32) * p2(7) + f3 * p2(12) + s1 * p2(15) + s2 * p2(20)
             + ((u / 32) % 128) * p2(25);
      end
      4: begin
        ok = (f3 != 2) && (f3 != 3) && (u % 2 == 0) && (s >= -4096) && (s <= 4094);
        w  = 'h63 + ((u / p2(11)) % 2) * p2(7) + ((u / 2) % 16) * p2(8) + f3 * p2(12)
             + s1 * p2(15) + s2 * p2(20) + ((u / 32) % 64) * p2(25)
             + ((u / p2(12)) % 2) * p2(31);
      end
      5, 6: begin
        ok = (u % 4096 == 0);
        w  = ((cls == 5) ? 'h37 : 'h17) + d * p2(7) + (u / 4096) * p2(12);
      end
      7: begin
        ok = (u % 2 == 0) && (s >= -1048576) && (s <= 1048574);
        w  = 'h6f + d * p2(7) + ((u / p2(12)) % 256) * p2(12) + ((u / p2(11)) % 2) * p2(20)
             + ((u / 2) % 1024) * p2(21) + ((u / p2(20)) % 2) * p2(31);
      end
      8: begin
        ok = (f3 == 0) && fits12;
        w  = 'h67 + d * p2(7) + s1 * p2(15) + (u % 4096) * p2(20);
      end
      default: ok = 0;
    endcase
    return ok ? {1'b0, w[31:0]} : {1'b1, 32'h0000_0013};
  endfunction

  // One clock cycle: drive, check pre-edge state against the model, clock, update model.
  task automatic tick(input bit v, input int cls, input int f3, input int a, input int d,
                      input int s1, input int s2, input logic [31:0] imm_v, input bit ordy);
    bit acc;
    bit pp;
    logic [32:0] e;
    in_valid  = v;
    op_class  = cls[3:0];
    funct3    = f3[2:0];
    alt       = a[0];
    rd        = d[4:0];
    rs1       = s1[4:0];
    rs2       = s2[4:0];
    imm       = imm_v;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("head_instr", out_instr, last_head[31:0]);
    check("head_err", 32'(out_err), 32'(last_head[32]));
    acc = v && (model_q.size() < DEPTH);
    pp  = (model_q.size() != 0) && ordy;
    e   = ref_enc(cls, f3, a, d, s1, s2, imm_v);
    @(posedge clk);
    #1;
    if (pp) void'(model_q.pop_front());
    if (acc) begin
      model_q.push_back(e);
      if (e[32]) begin
        if (exp_err < 65535) exp_err++;
      end else begin
        if (exp_enc < 65535) exp_enc++;
      end
    end
    if (model_q.size() != 0) last_head = model_q[0];
    in_valid = 1'b0;
    check("enc_count", 32'(enc_count), 32'(exp_enc));
    check("err_count", 32'(err_count), 32'(exp_err));
  endtask

  task automatic idle(input bit ordy);
    tick(0, 0, 0, 0, 0, 0, 0, 32'd0, ordy);
  endtask

  function automatic logic [31:0] rand_imm();
    int sel = $urandom_range(0, 4);
    int x;
    case (sel)
      0: return $urandom;
      1: x = int'($urandom_range(0, 80)) - 40;
      2: x = int'($urandom_range(0, 8400)) - 4200;
      3: return $urandom & 32'hFFFF_F000;
      default: x = int'($urandom_range(0, 2200000)) - 1100000;
    endcase
    return x;
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; op_class = '0; funct3 = '0; alt = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // add, sub back to back with the consumer always ready
    tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 1);
    check("add", out_instr, 32'h002081B3);
    tick(1, 0, 0, 1, 5, 6, 7, 32'd0, 1);
    check("sub", out_instr, 32'h407302B3);
    idle(1);
    check("enc_after_addsub", 32'(enc_count), 32'd2);

    tick(1, 1, 0, 0, 1, 0, 0, 32'd5, 1);
    check("addi", out_instr, 32'h00500093);
    tick(1, 1, 5, 1, 1, 2, 0, 32'd3, 1);
    check("srai", out_instr, 32'h40315093);
    tick(1, 3, 2, 0, 0, 2, 5, 32'd12, 1);
    check("sw", out_instr, 32'h00512623);
    check("sw_err", 32'(out_err), 32'd0);
    tick(1, 4, 0, 0, 0, 1, 2, 32'd8, 1);
    check("beq", out_instr, 32'h00208463);
    tick(1, 5, 0, 0, 1, 0, 0, 32'h12345000, 1);
    check("lui", out_instr, 32'h123450B7);
    tick(1, 4, 0, 0, 0, 1, 2, 32'd7, 1);
    check("beq_odd_instr", out_instr, 32'h00000013);
    check("beq_odd_err", 32'(out_err), 32'd1);
    check("beq_odd_errcnt", 32'(err_count), 32'd1);
    idle(1);

    // Backpressure: two fill the FIFO, third is held, then popping alone frees a slot
    tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 0);
    tick(1, 0, 0, 1, 5, 6, 7, 32'd0, 0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick(1, 1, 0, 0, 1, 0, 0, 32'd5, 0);
    check("held_head", out_instr, 32'h002081B3);
    tick(1, 1, 0, 0, 1, 0, 0, 32'd5, 1);
    check("pop_only_head", out_instr, 32'h407302B3);
    check("pop_only_ready", 32'(in_ready), 32'd1);
    tick(1, 1, 0, 0, 1, 0, 0, 32'd5, 1);
    check("third_head", out_instr, 32'h00500093);
    idle(1);
    check("drained", 32'(out_valid), 32'd0);
    check("drained_keep", out_instr, 32'h00500093);

    // Reset while two entries are queued
    tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 0);
    tick(1, 0, 0, 1, 5, 6, 7, 32'd0, 0);
    #2;
    rst = 1'b1;
    in_valid = 1'b1; op_class = 4'd1; funct3 = 3'd0; rd = 5'd9; imm = 32'd1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_enc", 32'(enc_count), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_instr", out_instr, 32'd0);
    model_q.delete();
    last_head = '0;
    exp_enc = 0;
    exp_err = 0;
    @(posedge clk);
    #1;
    check("rst_no_accept", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick(1, 1, 0, 0, 1, 0, 0, 32'd5, 1);
    check("post_rst_addi", out_instr, 32'h00500093);
    idle(1);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int cls = ($urandom_range(0, 7) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 15));
      tick($urandom_range(0, 3) != 0, cls, int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_imm(),
           $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential RV32I instruction encoder: the inverse of the main instruction decoder. It accepts a decoded operation (class, funct3, alt bit, register indices, immediate) over a valid/ready handshake. It checks field legality, packs the 32-bit instruction word in the standard R/I/S/B/U/J formats, and buffers results in a small output FIFO. It is used by the self-test program generator and the UART program loader to feed instruction memory, and by the testbench as the golden encoder for decoder checks.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 16, width of saturating encode/error counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request this cycle
op_class  input  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR
funct3  input  3  funct3 field (ignored for U/J classes)
alt  input  1  funct7[5] select (sub/sra/srai)
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2 (R/STORE/BRANCH only)
imm  input  32  immediate, signed value as in the assembly operand (U-type: full 32-bit value)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head this cycle
out_instr  output  32  encoded instruction at FIFO head
out_err  output  1  head entry was illegal (out_instr = 32'h00000013)
enc_count  output  CNT_W  legal instructions pushed, saturating
err_count  output  CNT_W  illegal requests pushed, saturating

Behaviour:
- Reset (async, immediate): FIFO empty, out_valid=0, out_instr=0, out_err=0, counters=0, in_ready=1 once rst deasserts.
- Accept: in_valid && in_ready at a rising edge. Encoding is combinational on the inputs. The result is written into the FIFO at that edge, so latency is 1 cycle: with an empty FIFO, out_valid=1 in the cycle after acceptance.
- in_ready = (count < DEPTH) and comes from registered state only. When full, a request is not accepted even if out_ready=1 in the same cycle.
- Pop: out_valid && out_ready at an edge. Simultaneous push and pop keeps count unchanged, and the FIFO order is preserved.
- out_instr/out_err show the FIFO head. They hold stable while out_valid && !out_ready. Empty FIFO: out_valid=0, out_instr/out_err keep their last value.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Formats:
  - R: funct7 = alt?0100000:0000000.
  - I-ALU shifts (funct3 001/101): imm[4:0] is shamt, funct7 = alt?0100000:0.
  - Other I-type: imm[11:0].
  - S/B/J: standard bit scatter.
  - U: imm[31:12].
  - JALR: funct3 forced 000.
- Illegal (entry pushed with out_err=1, out_instr=32'h00000013; err_count increments, enc_count does not):
  - op_class > 8.
  - R with alt=1 and funct3 not in {000,101}.
  - I-ALU with alt=1 and funct3 != 101.
  - I-ALU shift with imm outside 0..31.
  - LOAD funct3 in {011,110,111}.
  - STORE funct3 > 010.
  - BRANCH funct3 in {010,011}.
  - JALR funct3 != 000.
  - I/S/JALR imm outside -2048..2047.
  - BRANCH imm odd or outside -4096..4094.
  - JAL imm odd or outside -1048576..1048574.
  - LUI/AUIPC imm[11:0] != 0.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation discards all FIFO contents and counters. A request presented during reset is not accepted.

Test Plan:
- add x3,x1,x2 (class0,f3 000,alt0) then sub x5,x6,x7 (alt1) with out_ready=1 -> 0x002081B3 then 0x407302B3, each 1 cycle after accept, enc_count=2.
- addi x1,x0,5; srai x1,x2,3; sw x5,12(x2) -> 0x00500093, 0x40315093, 0x00512623, out_err=0.
- beq x1,x2,+8 and lui x1,0x12345000 -> 0x00208463, 0x123450B7; beq with imm=7 -> err=1, 0x00000013, err_count=1.
- Backpressure: out_ready=0, issue 3 requests with DEPTH=2 -> in_ready low after 2 accepts, third held; head stable; raise out_ready -> third accepted with order preserved.
- Full FIFO with push attempted while popping -> only the pop occurs; next cycle in_ready=1 and the push succeeds.
- Assert rst while FIFO holds 2 entries -> out_valid=0 and counters=0 immediately; addi x1,x0,5 after release -> 0x00500093.
